// File: rtl/opr_fetch_decode_if.sv
// Bus between the fetch/decode stage and its instruction memory and operand demux.
// The master side is the fetch/decode stage; the slave side is memory plus demux.
interface opr_fetch_decode_if #(
  parameter int unsigned PC_WIDTH  = 8,
  parameter int unsigned OPR_WIDTH = 8
);
  logic                 io_imem_req;
  logic [PC_WIDTH-1:0]  io_imem_addr;
  logic                 io_imem_valid;
  logic [15:0]          io_imem_data;
  logic [2:0]           io_OPR_sel;
  logic [OPR_WIDTH-1:0] io_operand;
  logic                 io_issue_valid;
  logic                 io_issue_ready;

  modport master (
    output io_imem_req,
    output io_imem_addr,
    input  io_imem_valid,
    input  io_imem_data,
    output io_OPR_sel,
    output io_operand,
    output io_issue_valid,
    input  io_issue_ready
  );

  modport slave (
    input  io_imem_req,
    input  io_imem_addr,
    output io_imem_valid,
    output io_imem_data,
    input  io_OPR_sel,
    input  io_operand,
    input  io_issue_valid,
    output io_issue_ready
  );
endinterface

// File: rtl/opr_fetch_decode.sv
// Fetch/decode stage: fetches 16-bit words at the PC, executes NOP/JMP/HALT/illegal
// internally and issues WTR/INC/RESET/WTA operands to the demux over valid/ready.
module opr_fetch_decode #(
  parameter int unsigned PC_WIDTH  = 8,
  parameter int unsigned OPR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_start,
  opr_fetch_decode_if.master    bus_io,
  output logic [PC_WIDTH-1:0]   io_pc,
  output logic                  io_halted,
  output logic                  io_illegal
);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StIssue, StHalted} state_e;
  typedef enum logic [2:0] {OpWtr, OpInc, OpRst, OpWta, OpNop, OpJmp, OpHalt, OpIll} opcode_e;

  localparam logic [2:0] SelNone = 3'd4;

  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [15:0]          ir_q, ir_d;
  logic [2:0]           sel_q, sel_d;
  logic [OPR_WIDTH-1:0] operand_q, operand_d;
  logic                 illegal_q, illegal_d;
  opcode_e              opcode;

  assign opcode = opcode_e'(ir_q[10:8]);

  // Bits above the opcode are don't-care unless a wide PC consumes them on JMP.
  logic unused_ir_hi;
  assign unused_ir_hi = ^ir_q[15:11];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    sel_d     = sel_q;
    operand_d = operand_q;
    illegal_d = illegal_q;
    unique case (state_q)
      StIdle: begin
        if (io_start) state_d = StFetch;
      end
      StFetch: begin
        if (bus_io.io_imem_valid) begin
          ir_d    = bus_io.io_imem_data;
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = StDecode;
        end
      end
      StDecode: begin
        unique case (opcode)
          OpWtr, OpInc, OpRst, OpWta: begin
            sel_d     = ir_q[10:8];
            operand_d = OPR_WIDTH'(ir_q[7:0]);
            state_d   = StIssue;
          end
          OpNop:  state_d = StFetch;
          OpJmp: begin
            pc_d    = ir_q[PC_WIDTH-1:0];
            state_d = StFetch;
          end
          OpHalt: state_d = StHalted;
          OpIll: begin
            illegal_d = 1'b1;
            state_d   = StFetch;
          end
        endcase
      end
      StIssue: begin
        if (bus_io.io_issue_ready) begin
          sel_d     = SelNone;
          operand_d = '0;
          state_d   = StFetch;
        end
      end
      StHalted: begin
        if (io_start) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_q      <= '0;
      sel_q     <= SelNone;
      operand_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      sel_q     <= sel_d;
      operand_q <= operand_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus_io.io_imem_req    = (state_q == StFetch);
  assign bus_io.io_imem_addr   = pc_q;
  assign bus_io.io_OPR_sel     = sel_q;
  assign bus_io.io_operand     = operand_q;
  assign bus_io.io_issue_valid = (state_q == StIssue);
  assign io_pc                 = pc_q;
  assign io_halted             = (state_q == StHalted);
  assign io_illegal            = illegal_q;

endmodule

// File: tb/tb_opr_fetch_decode.sv
// Directed bench for opr_fetch_decode: small instruction memory model, transfer and
// fetch-address monitors, and hand-computed expectations.
module tb_opr_fetch_decode;

  logic       clock;
  logic       reset;
  logic       io_start;
  logic [7:0] io_pc;
  logic       io_halted;
  logic       io_illegal;

  opr_fetch_decode_if #(.PC_WIDTH(8), .OPR_WIDTH(8)) bus ();

  opr_fetch_decode #(.PC_WIDTH(8), .OPR_WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .io_start   (io_start),
    .bus_io     (bus),
    .io_pc      (io_pc),
    .io_halted  (io_halted),
    .io_illegal (io_illegal)
  );

  logic [15:0] mem [256];
  logic        slow;
  logic        req_seen;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [2:0]  x_sel[$];
  logic [7:0]  x_opd[$];
  int          x_cyc[$];
  logic [7:0]  f_addr[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slow mode answers a fetch one cycle after req rises; otherwise zero-wait.
  assign bus.io_imem_valid = bus.io_imem_req && (!slow || req_seen);
  assign bus.io_imem_data  = mem[bus.io_imem_addr];

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    req_seen <= bus.io_imem_req;
  end

  always @(negedge clock) begin
    if (reset) begin
      x_sel.delete();
      x_opd.delete();
      x_cyc.delete();
      f_addr.delete();
    end else begin
      if (bus.io_issue_valid && bus.io_issue_ready) begin
        x_sel.push_back(bus.io_OPR_sel);
        x_opd.push_back(bus.io_operand);
        x_cyc.push_back(cyc);
      end
      if (bus.io_imem_req && bus.io_imem_valid) f_addr.push_back(bus.io_imem_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    io_start           = 1'b0;
    bus.io_issue_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0600;
  endtask

  task automatic pulse_start();
    io_start = 1'b1;
    tick();
    io_start = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (!bus.io_issue_valid && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.io_issue_valid), 1);
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!io_halted && n < 60) begin
      tick();
      n++;
    end
    check(tag, 32'(io_halted), 1);
  endtask

  initial begin
    int n;
    int exp_f[7];
    exp_f = '{0, 1, 2, 16, 17, 255, 0};
    slow = 1'b0;
    fill_mem();

    // Reset state and single WTR with one-cycle memory latency
    do_reset();
    check("rst_valid", 32'(bus.io_issue_valid), 0);
    check("rst_sel", 32'(bus.io_OPR_sel), 4);
    check("rst_opd", 32'(bus.io_operand), 0);
    check("rst_req", 32'(bus.io_imem_req), 0);
    check("rst_pc", 32'(io_pc), 0);
    check("rst_halt", 32'(io_halted), 0);
    check("rst_ill", 32'(io_illegal), 0);
    mem[0] = 16'h0006;
    slow   = 1'b1;
    pulse_start();
    check("s1_req", 32'(bus.io_imem_req), 1);
    check("s1_addr", 32'(bus.io_imem_addr), 0);
    tick();
    tick();
    check("s1_dec_valid", 32'(bus.io_issue_valid), 0);
    check("s1_dec_pc", 32'(io_pc), 1);
    tick();
    check("s1_valid", 32'(bus.io_issue_valid), 1);
    check("s1_sel", 32'(bus.io_OPR_sel), 0);
    check("s1_opd", 32'(bus.io_operand), 6);
    check("s1_pc", 32'(io_pc), 1);
    bus.io_issue_ready = 1'b1;
    tick();
    bus.io_issue_ready = 1'b0;
    check("s1_post_valid", 32'(bus.io_issue_valid), 0);
    check("s1_post_sel", 32'(bus.io_OPR_sel), 4);
    check("s1_post_opd", 32'(bus.io_operand), 0);
    check("s1_xfers", 32'(x_sel.size()), 1);
    check("s1_next_addr", 32'(bus.io_imem_addr), 1);

    // Straight-line program with ready tied high
    do_reset();
    fill_mem();
    slow = 1'b0;
    mem[0] = 16'h0105; mem[1] = 16'h0209; mem[2] = 16'h0311; mem[3] = 16'h0600;
    bus.io_issue_ready = 1'b1;
    pulse_start();
    wait_halt("s2_halt");
    check("s2_count", 32'(x_sel.size()), 3);
    check("s2_sel0", 32'(x_sel[0]), 1);
    check("s2_opd0", 32'(x_opd[0]), 5);
    check("s2_sel1", 32'(x_sel[1]), 2);
    check("s2_opd1", 32'(x_opd[1]), 9);
    check("s2_sel2", 32'(x_sel[2]), 3);
    check("s2_opd2", 32'(x_opd[2]), 32'h11);
    check("s2_gap01", 32'(x_cyc[1] - x_cyc[0]), 3);
    check("s2_gap12", 32'(x_cyc[2] - x_cyc[1]), 3);
    check("s2_pc", 32'(io_pc), 4);
    check("s2_req", 32'(bus.io_imem_req), 0);

    // Backpressure
    do_reset();
    fill_mem();
    mem[0] = 16'h0307;
    pulse_start();
    wait_issue("s3_issue");
    for (int i = 0; i < 5; i++) begin
      check("s3_hold_valid", 32'(bus.io_issue_valid), 1);
      check("s3_hold_sel", 32'(bus.io_OPR_sel), 3);
      check("s3_hold_opd", 32'(bus.io_operand), 7);
      check("s3_hold_req", 32'(bus.io_imem_req), 0);
      tick();
    end
    bus.io_issue_ready = 1'b1;
    tick();
    bus.io_issue_ready = 1'b0;
    check("s3_post_valid", 32'(bus.io_issue_valid), 0);
    check("s3_post_sel", 32'(bus.io_OPR_sel), 4);
    check("s3_post_opd", 32'(bus.io_operand), 0);
    wait_halt("s3_halt");
    check("s3_count", 32'(x_sel.size()), 1);

    // Control flow: NOP, illegal, JMP, PC wrap
    do_reset();
    fill_mem();
    mem[0] = 16'h0400; mem[1] = 16'h0700; mem[2] = 16'h0510;
    mem[16] = 16'h0101; mem[17] = 16'h05FF; mem[255] = 16'h0202;
    bus.io_issue_ready = 1'b1;
    pulse_start();
    n = 0;
    while (f_addr.size() < 7 && n < 100) begin
      tick();
      n++;
    end
    check("s4_fetches", 32'(f_addr.size()), 7);
    for (int i = 0; i < 7; i++) check("s4_faddr", 32'(f_addr[i]), 32'(exp_f[i]));
    check("s4_count", 32'(x_sel.size()), 2);
    check("s4_sel0", 32'(x_sel[0]), 1);
    check("s4_opd0", 32'(x_opd[0]), 1);
    check("s4_sel1", 32'(x_sel[1]), 2);
    check("s4_opd1", 32'(x_opd[1]), 2);
    check("s4_illegal", 32'(io_illegal), 1);

    // Reset during ISSUE with ready low
    bus.io_issue_ready = 1'b0;
    do_reset();
    check("s5_ill_clr", 32'(io_illegal), 0);
    fill_mem();
    mem[0] = 16'h0307;
    pulse_start();
    wait_issue("s5_issue");
    reset = 1'b1;
    tick();
    check("s5_valid", 32'(bus.io_issue_valid), 0);
    check("s5_sel", 32'(bus.io_OPR_sel), 4);
    check("s5_pc", 32'(io_pc), 0);
    reset = 1'b0;
    tick();
    check("s5_idle_req", 32'(bus.io_imem_req), 0);
    mem[0] = 16'h0105;
    pulse_start();
    check("s5_restart_req", 32'(bus.io_imem_req), 1);
    check("s5_restart_addr", 32'(bus.io_imem_addr), 0);

    // io_start ignored in FETCH/ISSUE; resumes after HALT
    do_reset();
    fill_mem();
    slow = 1'b1;
    mem[0] = 16'h0600; mem[1] = 16'h0105; mem[2] = 16'h0600;
    io_start = 1'b1;
    tick();
    tick();
    io_start = 1'b0;
    check("s6_fetch_req", 32'(bus.io_imem_req), 1);
    check("s6_fetch_addr", 32'(bus.io_imem_addr), 0);
    tick();
    tick();
    check("s6_halted", 32'(io_halted), 1);
    check("s6_halt_pc", 32'(io_pc), 1);
    check("s6_halt_req", 32'(bus.io_imem_req), 0);
    tick();
    tick();
    check("s6_still_halted", 32'(io_halted), 1);
    pulse_start();
    check("s6_resume_halt", 32'(io_halted), 0);
    check("s6_resume_req", 32'(bus.io_imem_req), 1);
    check("s6_resume_addr", 32'(bus.io_imem_addr), 1);
    wait_issue("s6_issue");
    pulse_start();
    check("s6_iss_valid", 32'(bus.io_issue_valid), 1);
    check("s6_iss_sel", 32'(bus.io_OPR_sel), 1);
    check("s6_iss_opd", 32'(bus.io_operand), 5);
    bus.io_issue_ready = 1'b1;
    wait_halt("s6_halt2");
    check("s6_pc2", 32'(io_pc), 3);
    check("s6_count", 32'(x_sel.size()), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/opr_fetch_decode.md
Name: opr_fetch_decode

Overview:
- Upstream stage of the operand demultiplexer.
- Fetches 16-bit instruction words from instruction memory at a program counter and decodes the opcode.
- Presents the operand byte and a 3-bit operand-select to the demux, with a valid/ready issue handshake.
- Handles NOP, JMP, HALT and illegal opcodes internally; these never reach the demux.

Parameters:
- PC_WIDTH, 8, width of program counter and instruction-memory address.
- OPR_WIDTH, 8, operand width; equals the demux io_operand width.

Ports:
- clock  input  1  single system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- io_start  input  1  start/resume pulse; honoured only in IDLE or HALTED
- io_imem_req  output  1  fetch request; address valid while high
- io_imem_addr  output  PC_WIDTH  fetch address (= PC)
- io_imem_valid  input  1  instruction word valid this cycle
- io_imem_data  input  16  instruction word: [10:8] opcode, [7:0] operand, [15:11] ignored
- io_OPR_sel  output  3  operand-select to demux
- io_operand  output  OPR_WIDTH  operand to demux
- io_issue_valid  output  1  io_OPR_sel/io_operand valid for consumption
- io_issue_ready  input  1  downstream accepts the issued operand
- io_pc  output  PC_WIDTH  current PC (debug)
- io_halted  output  1  high while in HALTED
- io_illegal  output  1  sticky flag; set on opcode 7

Behaviour:
- Reset (synchronous, sampled at clock edge with reset=1):
  - state=IDLE, PC=0, io_issue_valid=0, io_OPR_sel=3'd4, io_operand=0, io_illegal=0, io_halted=0, io_imem_req=0.
- Reset dominates every other input, including mid-ISSUE. io_issue_valid is low from the cycle after the reset edge; no handshake completes on that edge.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- Opcode map:
  - 0 WTR, 1 INC, 2 RESET, 3 WTA: issued to the demux.
  - 4 NOP, 5 JMP, 6 HALT, 7 illegal: internal only.
- Idle output values: when io_issue_valid=0, io_OPR_sel=3'd4 (routes nothing) and io_operand=0.
- States:
  - IDLE: io_start=1 -> FETCH.
  - FETCH: io_imem_req=1, io_imem_addr=PC. On io_imem_valid=1: latch io_imem_data into IR, PC<=PC+1 (mod 2^PC_WIDTH, 255 wraps to 0 at default), -> DECODE. io_imem_data is ignored outside FETCH.
  - DECODE (one cycle):
    - opcodes 0-3: load io_OPR_sel=IR[10:8], io_operand=IR[7:0], -> ISSUE.
    - 4: -> FETCH.
    - 5: PC<=IR[PC_WIDTH-1:0] (overrides the increment), -> FETCH.
    - 6: -> HALTED.
    - 7: io_illegal<=1, -> FETCH.
  - ISSUE: io_issue_valid=1; io_OPR_sel and io_operand held stable until the transfer.
    - Transfer occurs on an edge with valid&&ready.
    - Next cycle: io_issue_valid=0, outputs return to 3'd4/0, state=FETCH.
    - Ready may stall indefinitely.
    - Ready high outside ISSUE has no effect.
  - HALTED: io_halted=1, io_imem_req=0. io_start=1 -> FETCH, resuming at the current PC (the address after the HALT word).
- io_start in FETCH, DECODE or ISSUE is ignored.
- Latency: io_imem_valid at edge t -> DECODE during cycle t+1 -> io_issue_valid high from t+2. Minimum 3 cycles per issued instruction with zero-wait memory and ready tied high.
- io_illegal clears only on reset.
- JMP to its own address loops forever with no issue; this is legal.

Test Plan:
- Reset, io_start pulse, memory returns 0x0006 (WTR, operand 6) with valid one cycle after req -> io_issue_valid high two cycles after valid, io_OPR_sel=0, io_operand=6, io_pc=1.
- Program {0x0105, 0x0209, 0x0311, 0x0600}, ready tied high:
  - issues sel/operand 1/5, 2/9, 3/0x11 in order; no gaps beyond the 3-cycle minimum.
  - then io_halted=1, io_pc=4, io_imem_req=0.
- Backpressure: issue 0x0307 with ready low for 5 cycles -> valid held with sel=3, operand=7, no new io_imem_req. Ready high -> exactly one transfer, next cycle valid=0, sel=4, operand=0.
- Control flow:
  - at PC=2 word 0x0510 -> next fetch address 0x10.
  - 0x0400 -> no issue.
  - 0x0700 -> io_illegal=1, stays 1 after later valid instructions.
  - PC=255 fetch -> next address 0.
- Reset asserted during ISSUE (valid=1, ready=0) -> next cycle valid=0, sel=4, PC=0, state IDLE. io_start -> fetch from address 0.
- io_start pulsed during FETCH/ISSUE -> no effect on state. io_start in HALTED -> fetch resumes at the address after the HALT word.
